// File: rtl/issue_cdb_scheduler.sv
// Issue-stage scheduler: arbitrates RS ready lines into issue grants and keeps a
// CDB slot-reservation shift register so only one unit writes back per cycle.
module issue_cdb_scheduler #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready_int,
  input  logic       ready_ld_buf,
  input  logic       ready_mult,
  input  logic       ready_div,
  output logic       issue_int,
  output logic       issue_ld_buf,
  output logic       issue_mult,
  output logic       issue_div,
  output logic       div_busy,
  output logic       cdb_valid,
  output logic [1:0] cdb_owner
);

  localparam int CNT_W = $clog2(DIV_LAT);
  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [1:0] OWN_INT  = 2'd0;
  localparam logic [1:0] OWN_MULT = 2'd1;
  localparam logic [1:0] OWN_DIV  = 2'd2;
  localparam logic [1:0] OWN_LD   = 2'd3;

  logic [DIV_LAT:0] rsv;
  logic [1:0]       own [DIV_LAT:0];
  logic [CNT_W-1:0] div_cnt;
  logic             rr;

  logic [DIV_LAT:1] slot_set;
  logic [1:0]       slot_code [DIV_LAT:1];

  // Grants are combinational; the reset gate keeps them quiet while reset is held.
  always_comb begin
    issue_div    = 1'b0;
    issue_mult   = 1'b0;
    issue_int    = 1'b0;
    issue_ld_buf = 1'b0;
    if (!reset) begin
      issue_div  = ready_div && (div_cnt == '0) && !rsv[DIV_LAT];
      issue_mult = ready_mult && !rsv[MULT_LAT];
      if (!rsv[1]) begin
        if (ready_int && ready_ld_buf) begin
          // rr holds the last winner; the other one goes this time.
          issue_int    = rr;
          issue_ld_buf = !rr;
        end else begin
          issue_int    = ready_int;
          issue_ld_buf = ready_ld_buf;
        end
      end
    end
  end

  // Map each grant onto the reservation slot matching its latency.
  always_comb begin
    slot_set = '0;
    for (int k = 1; k <= DIV_LAT; k++) begin
      slot_code[k] = OWN_INT;
    end
    slot_set[1]         = issue_int | issue_ld_buf;
    slot_code[1]        = issue_ld_buf ? OWN_LD : OWN_INT;
    slot_set[MULT_LAT]  = issue_mult;
    slot_code[MULT_LAT] = OWN_MULT;
    slot_set[DIV_LAT]   = issue_div;
    slot_code[DIV_LAT]  = OWN_DIV;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsv <= '0;
      for (int i = 0; i <= DIV_LAT; i++) begin
        own[i] <= OWN_INT;
      end
      div_cnt <= '0;
      rr      <= 1'b1;
    end else begin
      for (int i = 0; i < DIV_LAT; i++) begin
        rsv[i] <= rsv[i+1] | slot_set[i+1];
        own[i] <= slot_set[i+1] ? slot_code[i+1] : own[i+1];
      end
      rsv[DIV_LAT] <= 1'b0;
      own[DIV_LAT] <= OWN_INT;

      if (issue_div) begin
        div_cnt <= DIV_RELOAD;
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - 1'b1;
      end

      if (issue_int) begin
        rr <= 1'b0;
      end else if (issue_ld_buf) begin
        rr <= 1'b1;
      end
    end
  end

  assign div_busy  = (div_cnt != '0);
  assign cdb_valid = rsv[0];
  assign cdb_owner = own[0];

endmodule
